// File: rtl/stack_pkg.sv
// Shared types for the LIFO stack: the per-cycle operation decode.
package stack_pkg;

  // What the stack actually does on a given edge, after the full/empty checks.
  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,  // nothing happens (also covers dropped requests)
    OP_PUSH = 2'd1,  // store at the free slot, grow by one
    OP_POP  = 2'd2,  // return the top entry, shrink by one
    OP_SWAP = 2'd3   // return the top entry and overwrite it in place
  } op_t;

  // Resolve the raw requests against the occupancy flags. Push+pop on an
  // empty stack degrades to a plain push; out-of-range requests become idle.
  function automatic op_t decode_op(input logic push, input logic pop,
                                    input logic full, input logic empty);
    op_t op;
    op = OP_IDLE;
    if (push && pop) begin
      op = empty ? OP_PUSH : OP_SWAP;
    end else if (push) begin
      op = full ? OP_IDLE : OP_PUSH;
    end else if (pop) begin
      op = empty ? OP_IDLE : OP_POP;
    end
    return op;
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x BANDWIDTH register array: one synchronous write port and one
// asynchronous read port, so the top can capture the old top-of-stack on the
// same edge that overwrites it.
module stack_regfile #(
  parameter int DEPTH     = 8,
  parameter int BANDWIDTH = 4,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [BANDWIDTH-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [BANDWIDTH-1:0] rdata
);

  logic [BANDWIDTH-1:0] mem [DEPTH];

  // Write port; contents are deliberately never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack.sv
// Parameterised synchronous LIFO stack with registered pop data and
// combinational full/empty flags decoded from the occupancy counter.
module stack
  import stack_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int BANDWIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 push,
  input  logic                 pop,
  input  logic [BANDWIDTH-1:0] data_in,
  output logic [BANDWIDTH-1:0] data_out,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]        stack_ptr;
  logic [PW-1:0]        ptr_next;
  op_t                  op;
  logic                 we;
  logic [AW-1:0]        waddr;
  logic [AW-1:0]        raddr;
  logic [BANDWIDTH-1:0] rdata;

  assign full  = (stack_ptr == PW'(DEPTH));
  assign empty = (stack_ptr == '0);

  // Decode the request into write-port controls and the next occupancy.
  always_comb begin
    op       = decode_op(push, pop, full, empty);
    we       = 1'b0;
    raddr    = AW'(stack_ptr - PW'(1));
    waddr    = AW'(stack_ptr);
    ptr_next = stack_ptr;
    case (op)
      OP_PUSH: begin
        we       = rstn;
        ptr_next = stack_ptr + PW'(1);
      end
      OP_POP: begin
        ptr_next = stack_ptr - PW'(1);
      end
      OP_SWAP: begin
        we    = rstn;
        waddr = raddr;
      end
      default: begin
      end
    endcase
  end

  // Occupancy counter and pop-data register; reset discards any request.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stack_ptr <= '0;
      data_out  <= '0;
    end else begin
      stack_ptr <= ptr_next;
      if (op == OP_POP || op == OP_SWAP) begin
        data_out <= rdata;
      end
    end
  end

  stack_regfile #(
    .DEPTH     (DEPTH),
    .BANDWIDTH (BANDWIDTH),
    .AW        (AW)
  ) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (data_in),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_stack.sv
// Self-checking bench for stack: directed walk through the basic scenarios
// with literal expectations, then randomized traffic against a queue model.
module tb_stack;

  localparam int DEPTH     = 8;
  localparam int BANDWIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 push = 1'b0;
  logic                 pop = 1'b0;
  logic [BANDWIDTH-1:0] data_in = '0;
  logic [BANDWIDTH-1:0] data_out;
  logic                 full;
  logic                 empty;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model: a queue whose back is the top of the stack.
  logic [BANDWIDTH-1:0] m_q[$];
  logic [BANDWIDTH-1:0] m_out = '0;

  stack #(.DEPTH(DEPTH), .BANDWIDTH(BANDWIDTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .pop      (pop),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on every rising edge from the sampled requests.
  always @(posedge clk) begin
    if (!rstn) begin
      m_q.delete();
      m_out = '0;
    end else if (push && pop) begin
      if (m_q.size() > 0) begin
        m_out = m_q[$];
        m_q[$] = data_in;
      end else begin
        m_q.push_back(data_in);
      end
    end else if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(data_in);
    end else if (pop) begin
      if (m_q.size() > 0) m_out = m_q.pop_back();
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model.data_out", int'(data_out), int'(m_out));
      check("model.stack_ptr", int'(dut.stack_ptr), m_q.size());
      check("model.full", int'(full), int'(m_q.size() == DEPTH));
      check("model.empty", int'(empty), int'(m_q.size() == 0));
    end
  end

  // Present one request for one clock; returns at the following negedge.
  task automatic cyc(input logic p, input logic po, input logic [BANDWIDTH-1:0] d,
                     input logic r);
    push = p; pop = po; data_in = d; rstn = r;
    @(negedge clk);
    $display("cyc rstn=%0b push=%0b pop=%0b din=%0d -> dout=%0d ptr=%0d full=%0b empty=%0b",
             r, p, po, d, data_out, dut.stack_ptr, full, empty);
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk_en = 1'b1;

    // Reset state
    check("rst.ptr", int'(dut.stack_ptr), 0);
    check("rst.empty", int'(empty), 1);
    check("rst.full", int'(full), 0);
    check("rst.dout", int'(data_out), 0);

    // Fill 0..7
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, BANDWIDTH'(i), 1);
      check("fill.ptr", int'(dut.stack_ptr), i + 1);
      check("fill.empty", int'(empty), 0);
      check("fill.full", int'(full), int'(i == DEPTH - 1));
    end

    // Push while full is dropped
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 4'b1001, 1);
      check("ovf.ptr", int'(dut.stack_ptr), 8);
      check("ovf.full", int'(full), 1);
    end

    // Drain: 7..0
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 0, 1);
      check("drain.dout", int'(data_out), 7 - i);
      check("drain.ptr", int'(dut.stack_ptr), 7 - i);
      check("drain.full", int'(full), 0);
      check("drain.empty", int'(empty), int'(i == DEPTH - 1));
    end

    // Pop while empty is dropped
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 1);
      check("udf.dout", int'(data_out), 0);
      check("udf.ptr", int'(dut.stack_ptr), 0);
      check("udf.empty", int'(empty), 1);
    end

    // Simultaneous push+pop replaces the top
    cyc(1, 0, 3, 1);
    cyc(1, 0, 5, 1);
    cyc(1, 1, 9, 1);
    check("swap.dout", int'(data_out), 5);
    check("swap.ptr", int'(dut.stack_ptr), 2);
    cyc(0, 1, 0, 1);
    check("swap.pop1", int'(data_out), 9);
    cyc(0, 1, 0, 1);
    check("swap.pop2", int'(data_out), 3);

    // Push+pop on empty acts as push
    cyc(1, 1, 6, 1);
    check("swapempty.ptr", int'(dut.stack_ptr), 1);
    check("swapempty.dout", int'(data_out), 3);
    cyc(0, 1, 0, 1);
    check("swapempty.pop", int'(data_out), 6);

    // Swap while full keeps it full
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, BANDWIDTH'(i + 2), 1);
    cyc(1, 1, 15, 1);
    check("swapfull.dout", int'(data_out), 9);
    check("swapfull.full", int'(full), 1);
    cyc(0, 1, 0, 1);
    check("swapfull.pop", int'(data_out), 15);

    // Reset mid-operation discards the request
    cyc(0, 1, 0, 1);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 2, 1);
    cyc(1, 0, 7, 0);
    check("rstmid.ptr", int'(dut.stack_ptr), 0);
    check("rstmid.empty", int'(empty), 1);
    check("rstmid.dout", int'(data_out), 0);

    // Randomized traffic with phases biased toward filling and draining
    for (int ph = 0; ph < 12; ph++) begin
      int bias;
      bias = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
      for (int i = 0; i < 150; i++) begin
        logic p, po, r;
        p  = ($urandom_range(0, 99) < bias);
        po = ($urandom_range(0, 99) < (100 - bias));
        r  = ($urandom_range(0, 99) != 0);
        push = p; pop = po; data_in = BANDWIDTH'($urandom); rstn = r;
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
